// File: rtl/uart_tx_arbiter_if.sv
// Bus bundle between the message sources, the arbiter and the shared uart_tx.
// The master modport is the arbiter's view; slave is the sources/transmitter side.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ-1:0]   grant;
    logic                 uart_tx_send;
    logic [7:0]           uart_tx_data;
    logic                 uart_tx_done;
    logic                 uart_tx_busy;
    logic                 abort;

    modport master (
        input  req_valid, req_data, req_last, uart_tx_done, uart_tx_busy,
        output req_ready, grant, uart_tx_send, uart_tx_data, abort
    );

    modport slave (
        output req_valid, req_data, req_last, uart_tx_done, uart_tx_busy,
        input  req_ready, grant, uart_tx_send, uart_tx_data, abort
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ framed-message sources.
// Optional stall timeout with abort pulse is built when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    uart_tx_arbiter_if.master   bus
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_e;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1 || TIMEOUT > 65535) begin : gParamCheck
        $error("uart_tx_arbiter: NUM_REQ or TIMEOUT out of range");
    end

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic               lastFlag_q, lastFlag_d;
    logic               send_q, send_d;
    logic [7:0]         data_q, data_d;

    logic [PW-1:0]      ownerIdx;
    logic [PW-1:0]      nextPtr;
    logic [PW-1:0]      searchIdx;
    logic [PW-1:0]      winnerIdx;
    logic               winnerFound;

`ifdef UART_ARB_TIMEOUT_EN
    logic [15:0]        tmoCnt_q, tmoCnt_d;
    logic               abort_q, abort_d;
`endif

    // Owner index decode and the first valid requester searching from ptr
    always_comb begin
        ownerIdx    = '0;
        searchIdx   = '0;
        winnerIdx   = '0;
        winnerFound = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                ownerIdx = PW'(i);
            end
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            searchIdx = PW'((int'(ptr_q) + k) % NUM_REQ);
            if (!winnerFound && bus.req_valid[searchIdx]) begin
                winnerFound = 1'b1;
                winnerIdx   = searchIdx;
            end
        end
        nextPtr = (ownerIdx == PW'(NUM_REQ - 1)) ? '0 : ownerIdx + PW'(1);
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        lastFlag_d = lastFlag_q;
        send_d     = 1'b0;
        data_d     = data_q;
`ifdef UART_ARB_TIMEOUT_EN
        tmoCnt_d   = tmoCnt_q;
        abort_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (winnerFound && !bus.uart_tx_busy) begin
                    grant_d            = '0;
                    grant_d[winnerIdx] = 1'b1;
                    state_d            = SEND;
`ifdef UART_ARB_TIMEOUT_EN
                    tmoCnt_d           = '0;
`endif
                end
            end
            SEND: begin
                if (bus.req_valid[ownerIdx]) begin
                    data_d     = bus.req_data[{ownerIdx, 3'b000} +: 8];
                    send_d     = 1'b1;
                    lastFlag_d = bus.req_last[ownerIdx];
                    state_d    = WAIT;
                end
`ifdef UART_ARB_TIMEOUT_EN
                // A stalled owner loses the transmitter; bytes already sent stay sent
                else if (tmoCnt_q == 16'(TIMEOUT - 1)) begin
                    abort_d = 1'b1;
                    grant_d = '0;
                    ptr_d   = nextPtr;
                    state_d = IDLE;
                end else begin
                    tmoCnt_d = tmoCnt_q + 16'd1;
                end
`endif
            end
            WAIT: begin
                if (bus.uart_tx_done) begin
                    if (lastFlag_q) begin
                        grant_d = '0;
                        ptr_d   = nextPtr;
                        state_d = IDLE;
                    end else begin
                        state_d = SEND;
`ifdef UART_ARB_TIMEOUT_EN
                        tmoCnt_d = '0;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            ptr_q      <= '0;
            lastFlag_q <= 1'b0;
            send_q     <= 1'b0;
            data_q     <= 8'h00;
`ifdef UART_ARB_TIMEOUT_EN
            tmoCnt_q   <= '0;
            abort_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            lastFlag_q <= lastFlag_d;
            send_q     <= send_d;
            data_q     <= data_d;
`ifdef UART_ARB_TIMEOUT_EN
            tmoCnt_q   <= tmoCnt_d;
            abort_q    <= abort_d;
`endif
        end
    end

    assign bus.req_ready    = (state_q == SEND) ? grant_q : '0;
    assign bus.grant        = grant_q;
    assign bus.uart_tx_send = send_q;
    assign bus.uart_tx_data = data_q;
`ifdef UART_ARB_TIMEOUT_EN
    assign bus.abort        = abort_q;
`else
    assign bus.abort        = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: sources, a uart_tx model and a send monitor.
// The timeout scenario is included only when UART_ARB_TIMEOUT_EN is defined.
module tb_uart_tx_arbiter;
    localparam int NUM_REQ = 4;
`ifdef UART_ARB_TIMEOUT_EN
    localparam int TB_TIMEOUT = 10;
`else
    localparam int TB_TIMEOUT = 255;
`endif

    typedef struct {
        int         src;
        logic [7:0] data;
        bit         last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t               expQ[$];
    logic [8:0]         srcQ[NUM_REQ][$];
    logic [NUM_REQ-1:0] holdMask  = '0;
    logic               txBusy    = 1'b0;
    logic               txDone    = 1'b0;
    logic               extBusy   = 1'b0;
    int                 txCnt     = 0;
    int                 doneDelay = 3;
    int                 modelPtr  = 0;
    int                 checks    = 0;
    int                 errors    = 0;

    assign bus.uart_tx_busy = txBusy | extBusy;
    assign bus.uart_tx_done = txDone;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic driveReqs();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (srcQ[i].size() > 0) begin
                bus.req_valid[i]        = !holdMask[i];
                bus.req_data[8*i +: 8]  = srcQ[i][0][7:0];
                bus.req_last[i]         = srcQ[i][0][8];
            end else begin
                bus.req_valid[i]        = 1'b0;
                bus.req_data[8*i +: 8]  = 8'h00;
                bus.req_last[i]         = 1'b0;
            end
        end
    endtask

    function automatic bit queuesEmpty();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (srcQ[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic flushAll();
        expQ.delete();
        for (int i = 0; i < NUM_REQ; i++) srcQ[i].delete();
    endtask

    task automatic pushByte(input int src, input logic [7:0] data, input bit last);
        exp_t e;
        e.src  = src;
        e.data = data;
        e.last = last;
        srcQ[src].push_back({last, data});
        expQ.push_back(e);
    endtask

    // Every source in mask gets one random message; served one whole message at a time
    // in round-robin order starting from the modelled pointer
    task automatic applyStimulus(input logic [NUM_REQ-1:0] mask, input int maxLen);
        logic [8:0] msg[NUM_REQ][$];
        exp_t       e;
        int         len;
        int         s;
        int         lastServed;
        lastServed = modelPtr;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (mask[i]) begin
                len = int'($urandom_range(maxLen, 1));
                for (int b = 0; b < len; b++) msg[i].push_back({(b == len - 1), 8'($urandom)});
            end
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            s = (modelPtr + k) % NUM_REQ;
            if (mask[s]) begin
                foreach (msg[s][b]) begin
                    e.src  = s;
                    e.data = msg[s][b][7:0];
                    e.last = msg[s][b][8];
                    expQ.push_back(e);
                end
                lastServed = s;
            end
        end
        modelPtr = (lastServed + 1) % NUM_REQ;
        for (int i = 0; i < NUM_REQ; i++) begin
            foreach (msg[i][b]) srcQ[i].push_back(msg[i][b]);
        end
    endtask

    task automatic waitDrain(input int maxCycles);
        int n;
        bit finished;
        n = 0;
        finished = 1'b0;
        while (!finished) begin
            @(negedge clk);
            #2;
            if (expQ.size() == 0 && queuesEmpty() && bus.grant == '0 && !txBusy) begin
                finished = 1'b1;
            end else if (++n >= maxCycles) begin
                errors++;
                $display("[TB] FAIL drainTimeout pending=%0d limit=%0d cycles", expQ.size(), maxCycles);
                flushAll();
                finished = 1'b1;
            end
        end
        checks++;
        repeat (2) @(negedge clk);
    endtask

    task automatic waitSend(input int maxCycles);
        int n;
        n = 0;
        while (!bus.uart_tx_send && n < maxCycles) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("sendSeenInTime", int'(bus.uart_tx_send), 1);
    endtask

    // Requesters: byte handshakes seen mid-cycle are retired after the next rising edge
    initial begin
        logic [NUM_REQ-1:0] hs;
        driveReqs();
        forever begin
            @(negedge clk);
            hs = bus.req_ready & bus.req_valid;
            @(posedge clk);
            #1;
            if (!rst) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (hs[i] && srcQ[i].size() > 0) void'(srcQ[i].pop_front());
                end
            end
            driveReqs();
        end
    end

    // Transmitter model: busy from send until a one-cycle done doneDelay cycles later
    initial begin
        forever begin
            @(negedge clk);
            txDone = 1'b0;
            if (rst) begin
                txBusy = 1'b0;
                txCnt  = 0;
            end else if (bus.uart_tx_send) begin
                txBusy = 1'b1;
                txCnt  = doneDelay;
            end else if (txCnt > 0) begin
                txCnt--;
                if (txCnt == 0) begin
                    txDone = 1'b1;
                    txBusy = 1'b0;
                end
            end
        end
    end

    // Monitor: every send pulse is matched against the scoreboard head
    initial begin
        exp_t e;
        bit   haveCur;
        bit   curLast;
        int   curSrc;
        int   pend;
        haveCur = 1'b0;
        curLast = 1'b0;
        curSrc  = 0;
        pend    = 0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                haveCur = 1'b0;
                pend    = 0;
            end else begin
                if (pend == 1) checkOutput("grantClearAfterLast", int'(bus.grant), 0);
                if (pend == 2) checkOutput("readyAfterDone", int'(bus.req_ready), 1 << curSrc);
                pend = 0;
                if (bus.uart_tx_send) begin
                    if (expQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpectedSend actual=0x%0h expected=none", bus.uart_tx_data);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("txData", int'(bus.uart_tx_data), int'(e.data));
                        checkOutput("grantAtSend", int'(bus.grant), 1 << e.src);
                        haveCur = 1'b1;
                        curLast = e.last;
                        curSrc  = e.src;
                    end
                end
                if (txDone && haveCur) begin
                    pend    = curLast ? 1 : 2;
                    haveCur = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        // Power-up reset: outputs must clear without any clock edge
        #1 rst = 1'b1;
        #1;
        checkOutput("resetGrant", int'(bus.grant), 0);
        checkOutput("resetReady", int'(bus.req_ready), 0);
        checkOutput("resetSend", int'(bus.uart_tx_send), 0);
        checkOutput("resetData", int'(bus.uart_tx_data), 0);
        checkOutput("resetAbort", int'(bus.abort), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] simultaneous requests, two rounds");
        applyStimulus(4'b1111, 1);
        waitDrain(2000);
        applyStimulus(4'b1111, 1);
        waitDrain(2000);

        $display("[TB] single source, done 20 cycles after each send");
        doneDelay = 20;
        pushByte(1, 8'h42, 1'b0);
        pushByte(1, 8'h61, 1'b0);
        pushByte(1, 8'h0A, 1'b1);
        modelPtr = 2;
        waitDrain(2000);

        $display("[TB] grant lock");
        doneDelay = 5;
        pushByte(2, 8'h5A, 1'b0);
        pushByte(2, 8'hC7, 1'b1);
        waitSend(200);
        pushByte(0, 8'h3C, 1'b1);
        modelPtr = 1;
        waitDrain(2000);

        $display("[TB] busy gating");
        @(negedge clk);
        extBusy = 1'b1;
        pushByte(3, 8'hA5, 1'b1);
        modelPtr = 0;
        repeat (6) @(negedge clk);
        checkOutput("grantWhileBusy", int'(bus.grant), 0);
        extBusy = 1'b0;
        @(negedge clk);
        checkOutput("grantAfterBusyFalls", int'(bus.grant), 1 << 3);
        waitDrain(2000);

        $display("[TB] reset mid-message");
        applyStimulus(4'b0010, 1);
        waitDrain(2000);
        doneDelay = 8;
        pushByte(1, 8'hC3, 1'b0);
        pushByte(1, 8'h77, 1'b0);
        pushByte(1, 8'h18, 1'b1);
        waitSend(200);
        #1 rst = 1'b1;
        #1;
        checkOutput("midResetGrant", int'(bus.grant), 0);
        checkOutput("midResetReady", int'(bus.req_ready), 0);
        checkOutput("midResetSend", int'(bus.uart_tx_send), 0);
        checkOutput("midResetData", int'(bus.uart_tx_data), 0);
        checkOutput("midResetAbort", int'(bus.abort), 0);
        flushAll();
        modelPtr = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        doneDelay = 3;
        applyStimulus(4'b1111, 1);
        waitDrain(2000);

`ifdef UART_ARB_TIMEOUT_EN
        $display("[TB] stall timeout");
        doneDelay = 4;
        pushByte(1, 8'h11, 1'b0);
        srcQ[1].push_back({1'b1, 8'h22});
        pushByte(2, 8'h33, 1'b1);
        waitSend(200);
        holdMask[1] = 1'b1;
        n = 0;
        while (!bus.req_ready[1] && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("ownerReentersSend", int'(bus.req_ready[1]), 1);
        n = 0;
        while (!bus.abort && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("abortLatency", n, TB_TIMEOUT);
        checkOutput("grantClearedOnAbort", int'(bus.grant), 0);
        srcQ[1].delete();
        holdMask[1] = 1'b0;
        modelPtr = 3;
        waitDrain(2000);
`endif

        $display("[TB] randomized rounds");
        for (int r = 0; r < 25; r++) begin
            doneDelay = int'($urandom_range(6, 1));
            applyStimulus(NUM_REQ'($urandom_range(15, 1)), 3);
            waitDrain(3000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
